mem_lsu_axi: RTL
================

// Module: mem_lsu_axi
// PURPOSE
//  Parametrised MEM-stage load/store unit. It takes one load or store at a time from the MEM stage and drives single-beat AXI3 AR/R/AW/W/B.
//  Stores are posted into a WBUF_DEPTH FIFO, so the MEM stage completes them without waiting for B.
//  Loads are strongly ordered behind all buffered and in-flight stores.
//  The unit does sub-word lane steering and sign/zero extension, and detects misaligned accesses.
// PARAMETERS
//  LOAD_ID     4'd1  arid value; only R beats with rid==LOAD_ID are consumed
//  STORE_ID    4'd1  awid value; only B with bid==STORE_ID is consumed
//  WBUF_DEPTH  4     store-buffer entries, power of 2, >=2
//  KSEG_MAP    1     1: addr[31:30]==2'b10 maps to {3'b000,addr[28:0]}; 0: identity
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous reset, active-high
//  req_valid  in   1   MEM-stage request present
//  req_ready  out  1   request accepted this cycle when req_valid&req_ready
//  req_store  in   1   1=store, 0=load
//  req_size   in   2   0=byte, 1=half, 2=word (3 treated as word)
//  req_sign   in   1   load: sign-extend sub-word result
//  req_addr   in   32  virtual address
//  req_wdata  in   32  store data, right-aligned
//  resp_valid out  1   1-cycle completion pulse
//  resp_err   out  1   with resp_valid: misaligned, no bus access made
//  resp_rdata out  32  with resp_valid on load: extended load data
//  arid/araddr/arlen/arsize/arvalid  out 4/32/4/3/1; arready in 1
//  rid/rdata/rvalid in 4/32/1; rready out 1
//  awid/awaddr/awlen/awsize/awvalid  out 4/32/4/3/1; awready in 1
//  wdata/wstrb/wlast/wvalid  out 32/4/1/1; wready in 1
//  bid/bvalid in 4/1; bready out 1
// BEHAVIOUR
//  Reset: all valids, readies, resp_* and FIFO count = 0. Both FSMs go to IDLE.
//   Reset asserted mid-transaction abandons it; the interconnect is reset together.
//  Address: phys = KSEG_MAP&&addr[31:30]==2'b10 ? {3'b0,addr[28:0]} : addr. arlen=awlen=0, wlast=1.
//   arsize/awsize = req_size (3→2).
//  Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
//   Accepted when req_ready=1; resp_valid=1, resp_err=1 next cycle. No FIFO push, no AR.
//  req_ready = lfsm==L_IDLE && !resp_valid && (store ? !full : (fifo empty && sfsm==S_IDLE)).
//   A misaligned request ignores the full/empty terms.
//  Store accept: push {phys,size,wdata,wstrb} to FIFO. resp_valid pulses next cycle, resp_err=0.
//   Lanes: byte: wdata={4{d[7:0]}}, wstrb=4'b0001<<a[1:0].
//   Half: wdata={2{d[15:0]}}, wstrb=a[1]?1100:0011. Word: d, 1111.
//  Store drain FSM, one write outstanding:
//   S_IDLE: FIFO non-empty -> S_AWW; awvalid=wvalid=1 from the head entry.
//   S_AWW: awvalid drops after its handshake, wvalid after its own, in either order or the same cycle.
//    Pop head and -> S_B when both are done.
//   S_B: bready=1; bvalid&&bid==STORE_ID -> S_IDLE. A B response with a mismatched bid is ignored.
//  FIFO: a push and a pop in the same cycle both occur, count unchanged. Pointers wrap mod WBUF_DEPTH.
//   Full blocks stores only.
//  Load FSM:
//   L_IDLE: aligned load accepted -> L_AR, arvalid=1.
//   L_AR: arvalid and araddr held stable until arready -> L_R.
//   L_R: rready=1; rvalid&&rid==LOAD_ID -> latch rdata, -> L_RSP. Other rid ignored.
//   L_RSP: resp_valid=1 for one cycle, -> L_IDLE.
//   Load latency with zero-wait slave: accept cycle + 3.
//  Load extract: b = rdata byte at a[1:0]; h = a[1] ? rdata[31:16] : rdata[15:0].
//   Result: byte {{24{sign&b[7]}},b}, half {{16{sign&h[15]}},h}, word rdata.
//  resp_rdata holds its value until the next load response.
// TESTING
//  1 Reset pulse mid-load (L_R) -> next cycle arvalid=awvalid=wvalid=rready=bready=resp_valid=0, req_ready=1.
//  2 lw 0x8000_0010, zero-wait slave, rdata 0xDEADBEEF -> araddr 0x0000_0010, arsize 2,
//    resp_rdata 0xDEADBEEF at accept+3.
//  3 lb signed 0x0000_1003, rdata 0x80AA_5511 -> 0xFFFF_FF80.
//    lhu 0x0000_1002, rdata 0x8001_0000 -> 0x0000_8001. R beat with rid=0 first is ignored.
//  4 awready held 0, 4 sb to 0x0..0x3 data 0x12 -> req_ready=0 on 5th store.
//    Release awready/wready -> 4 writes in order, wstrb 0001,0010,0100,1000, wdata 0x12121212.
//  5 sw 0x100 then lw 0x100, bvalid delayed 10 cycles -> arvalid stays 0 until the cycle after the B handshake.
//  6 lw 0x0000_0002 -> resp_valid=1, resp_err=1 after 1 cycle. arvalid never asserts, FIFO count unchanged.

Source files
------------

// File: rtl/mem_lsu_axi.sv
// mem_lsu_axi: MEM-stage load/store unit that issues single-beat AXI3 reads and posted writes.
// Latency: loads complete at accept+3 with a zero-wait slave; stores and misaligned requests at accept+1.
// Backpressure: req_ready drops while busy, while a response pulses, when a store meets a full
//   buffer, or when a load must wait for buffered/in-flight stores.
// Ports: clk/reset; req_* MEM-stage request; resp_* completion pulse with error and load data;
//   ar*/r* single-beat read channel; aw*/w*/b* single-beat write channels.

module lsu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
endmodule

module mem_lsu_axi #(
  parameter logic [3:0] LOAD_ID    = 4'd1,
  parameter logic [3:0] STORE_ID   = 4'd1,
  parameter int         WBUF_DEPTH = 4,
  parameter bit         KSEG_MAP   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [1:0] {L_IDLE, L_AR, L_R, L_RSP} lstate_t;
  typedef enum logic [1:0] {S_IDLE, S_AWW, S_B}       sstate_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [3:0]  strb;
  } wbuf_t;

  lstate_t     lstate;
  sstate_t     sstate;
  wbuf_t       push_ent;
  wbuf_t       head_ent;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_pop;

  logic [31:0] phys;
  logic        misaligned;
  logic [2:0]  req_axsize;
  logic        accept;
  logic        acc_err;
  logic        acc_store;
  logic        acc_load;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  logic [1:0]  ld_off;
  logic [1:0]  ld_size;
  logic        ld_sign;
  logic [31:0] ld_shift;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  assign arid  = LOAD_ID;
  assign awid  = STORE_ID;
  assign arlen = 4'd0;
  assign awlen = 4'd0;
  assign wlast = 1'b1;

  // kseg0-style window folds onto low physical memory
  assign phys = (KSEG_MAP && req_addr[31:30] == 2'b10) ? {3'b000, req_addr[28:0]} : req_addr;

  assign misaligned = (req_size == 2'd1 && req_addr[0]) ||
                      (req_size[1] && req_addr[1:0] != 2'b00);
  assign req_axsize = (req_size == 2'd3) ? 3'd2 : {1'b0, req_size};

  // Misaligned requests never touch the buffer or the bus, so they skip the ordering terms
  always_comb begin
    req_ready = 1'b0;
    if (lstate == L_IDLE && !resp_valid) begin
      if (misaligned)     req_ready = 1'b1;
      else if (req_store) req_ready = !fifo_full;
      else                req_ready = fifo_empty && sstate == S_IDLE;
    end
  end

  assign accept    = req_valid && req_ready;
  assign acc_err   = accept && misaligned;
  assign acc_store = accept && !misaligned && req_store;
  assign acc_load  = accept && !misaligned && !req_store;

  always_comb begin
    st_wdata = req_wdata;
    st_wstrb = 4'b1111;
    case (req_size)
      2'd0: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'd1: begin
        st_wdata = {2{req_wdata[15:0]}};
        st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = req_wdata;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  assign push_ent = '{addr: phys, size: req_axsize, data: st_wdata, strb: st_wstrb};

  lsu_fifo #(.WIDTH($bits(wbuf_t)), .DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk      (clk),
    .reset    (reset),
    .push     (acc_store),
    .push_dat (push_ent),
    .pop      (fifo_pop),
    .head_dat (head_ent),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Head leaves the buffer only once both AW and W have handshaken (this cycle or earlier)
  assign fifo_pop = (sstate == S_AWW) && (!awvalid || awready) && (!wvalid || wready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sstate  <= S_IDLE;
      awvalid <= 1'b0;
      awaddr  <= '0;
      awsize  <= '0;
      wvalid  <= 1'b0;
      wdata   <= '0;
      wstrb   <= '0;
      bready  <= 1'b0;
    end else begin
      case (sstate)
        S_IDLE: begin
          if (!fifo_empty) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awaddr  <= head_ent.addr;
            awsize  <= head_ent.size;
            wdata   <= head_ent.data;
            wstrb   <= head_ent.strb;
            sstate  <= S_AWW;
          end
        end
        S_AWW: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (fifo_pop) begin
            bready <= 1'b1;
            sstate <= S_B;
          end
        end
        S_B: begin
          if (bvalid && bid == STORE_ID) begin
            bready <= 1'b0;
            sstate <= S_IDLE;
          end
        end
        default: sstate <= S_IDLE;
      endcase
    end
  end

  assign ld_shift = rdata >> {ld_off, 3'b000};
  assign ld_b     = ld_shift[7:0];
  assign ld_h     = ld_off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (ld_size)
      2'd0:    ld_ext = {{24{ld_sign & ld_b[7]}}, ld_b};
      2'd1:    ld_ext = {{16{ld_sign & ld_h[15]}}, ld_h};
      default: ld_ext = rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lstate     <= L_IDLE;
      arvalid    <= 1'b0;
      araddr     <= '0;
      arsize     <= '0;
      rready     <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      ld_off     <= '0;
      ld_size    <= '0;
      ld_sign    <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (lstate)
        L_IDLE: begin
          if (acc_err) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else if (acc_store) begin
            resp_valid <= 1'b1;
          end else if (acc_load) begin
            arvalid <= 1'b1;
            araddr  <= phys;
            arsize  <= req_axsize;
            ld_off  <= req_addr[1:0];
            ld_size <= req_size;
            ld_sign <= req_sign;
            lstate  <= L_AR;
          end
        end
        L_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            lstate  <= L_R;
          end
        end
        L_R: begin
          if (rvalid && rid == LOAD_ID) begin
            rready     <= 1'b0;
            resp_rdata <= ld_ext;
            resp_valid <= 1'b1;
            lstate     <= L_RSP;
          end
        end
        L_RSP: lstate <= L_IDLE;
        default: lstate <= L_IDLE;
      endcase
    end
  end
endmodule
